// File: rtl/add_arb_pkg.sv
// Shared constants, widths and state encoding for the round-robin arbiter
// that fronts the single 4-bit adder.
package add_arb_pkg;

   localparam int NREQ_DEF = 4;
   localparam int OP_W     = 4;
   localparam int SUM_W    = 5;
   localparam int ID_W     = $clog2(NREQ_DEF);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

   // Index width for a given requester count; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bundle between NREQ requesters, the arbiter and the
// result consumer.
interface add_arbiter_if
   import add_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) ();

   localparam int IDW = id_width(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [OP_W*NREQ-1:0] req_a;
   logic [OP_W*NREQ-1:0] req_b;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [SUM_W-1:0]     rsp_sum;
   logic                 rsp_ready;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum
   );

endinterface

// File: rtl/add.sv
// Existing 4-bit adder with carry out; shared by every requester.
module add (
   input  logic [3:0] num1,
   input  logic [3:0] num2,
   output logic [3:0] out,
   output logic       cout
);

   // Five-bit sum so the carry is never lost.
   always_comb begin
      {cout, out} = {1'b0, num1} + {1'b0, num2};
   end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter granting one requester per cycle access to a single
// shared adder; the sum is held in a one-entry result register.
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   add_arbiter_if.slave  bus
);

   localparam int IDW = id_width(NREQ);

   arb_state_e       state_r;
   logic [IDW-1:0]   rr_ptr_r;
   logic [IDW-1:0]   rsp_id_r;
   logic [SUM_W-1:0] rsp_sum_r;

   logic [IDW-1:0]   idx_s;
   logic [IDW-1:0]   win_s;
   logic             found_s;
   logic             slot_free_s;
   logic             xfer_s;
   logic [NREQ-1:0]  ready_s;
   logic [OP_W-1:0]  op_a_s;
   logic [OP_W-1:0]  op_b_s;
   logic [OP_W-1:0]  add_out_s;
   logic             add_cout_s;

   // Scan downward so the requester closest to rr_ptr is the last to overwrite the winner.
   always_comb begin
      idx_s   = {IDW{1'b0}};
      win_s   = {IDW{1'b0}};
      found_s = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx_s = rr_ptr_r + IDW'(k);
         if (bus.req_valid[idx_s]) begin
            win_s   = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign slot_free_s = (state_r == EMPTY) || bus.rsp_ready;
   // Gating with rst_n keeps grants quiet for the whole reset assertion.
   assign xfer_s      = found_s && slot_free_s && rst_n;

   // One-hot accept strobe for the winner of this cycle.
   always_comb begin
      ready_s = {NREQ{1'b0}};
      if (xfer_s) begin
         ready_s[win_s] = 1'b1;
      end else begin
         ready_s = {NREQ{1'b0}};
      end
   end

   // Steer the winner's operands into the shared adder.
   always_comb begin
      op_a_s = bus.req_a[OP_W*win_s +: OP_W];
      op_b_s = bus.req_b[OP_W*win_s +: OP_W];
   end

   add u_add (
      .num1 (op_a_s),
      .num2 (op_b_s),
      .out  (add_out_s),
      .cout (add_cout_s)
   );

   // Result register, occupancy state and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= EMPTY;
         rr_ptr_r  <= {IDW{1'b0}};
         rsp_id_r  <= {IDW{1'b0}};
         rsp_sum_r <= {SUM_W{1'b0}};
      end else if (xfer_s) begin
         state_r   <= FULL;
         rsp_sum_r <= {add_cout_s, add_out_s};
         rsp_id_r  <= win_s;
         rr_ptr_r  <= win_s + IDW'(1);
      end else if ((state_r == FULL) && bus.rsp_ready) begin
         state_r   <= EMPTY;
      end else begin
         state_r   <= state_r;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = (state_r == FULL);
   assign bus.rsp_id    = rsp_id_r;
   assign bus.rsp_sum   = rsp_sum_r;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with four requesters and hand-computed sums.
module tb_add_arbiter;

   logic clk;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   add_arbiter_if #(.NREQ(4)) bif ();

   add_arbiter #(.NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      bif.req_a[4*i +: 4] = a;
      bif.req_b[4*i +: 4] = b;
   endtask

   int exp_id  [6] = '{0, 1, 2, 3, 0, 1};
   int exp_sum [6] = '{8, 10, 12, 14, 8, 10};

   initial begin
      rst_n         = 1'b0;
      bif.req_valid = 4'hF;
      bif.req_a     = 16'h0000;
      bif.req_b     = 16'h0000;
      bif.rsp_ready = 1'b0;
      #2;
      check("rst_valid", bif.rsp_valid, 0);
      check("rst_id",    bif.rsp_id,    0);
      check("rst_sum",   bif.rsp_sum,   0);
      check("rst_ready", bif.req_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n         = 1'b1;

      // all four requesting: strict rotation starting at 0
      for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'(i + 8));
      bif.rsp_ready = 1'b1;
      bif.req_valid = 4'hF;
      #1;
      for (int n = 0; n < 6; n++) begin
         check($sformatf("rr_ready%0d", n), bif.req_ready, 32'(1) << exp_id[n]);
         tick();
         check($sformatf("rr_valid%0d", n), bif.rsp_valid, 1);
         check($sformatf("rr_id%0d", n),    bif.rsp_id,    exp_id[n]);
         check($sformatf("rr_sum%0d", n),   bif.rsp_sum,   exp_sum[n]);
      end
      bif.req_valid = 4'h0;
      tick();
      check("pop_valid", bif.rsp_valid, 0);
      check("pop_hold",  bif.rsp_sum,   10);

      // 15 + 15 from requester 2
      bif.req_valid = 4'b0100;
      set_op(2, 4'd15, 4'd15);
      #1;
      check("r2_ready", bif.req_ready, 4'b0100);
      tick();
      bif.req_valid = 4'h0;
      check("r2_valid", bif.rsp_valid, 1);
      check("r2_id",    bif.rsp_id,    2);
      check("r2_sum",   bif.rsp_sum,   5'b11110);

      // back-pressure with requester 1 waiting
      bif.req_valid = 4'b0010;
      set_op(1, 4'd5, 4'd6);
      bif.rsp_ready = 1'b0;
      #1;
      check("bp_ready0", bif.req_ready, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp_ready%0d", c + 1), bif.req_ready, 0);
         check($sformatf("bp_valid%0d", c + 1), bif.rsp_valid, 1);
         check($sformatf("bp_id%0d", c + 1),    bif.rsp_id,    2);
         check($sformatf("bp_sum%0d", c + 1),   bif.rsp_sum,   30);
      end
      bif.rsp_ready = 1'b1;
      #1;
      check("bp_release", bif.req_ready, 4'b0010);
      tick();
      bif.req_valid = 4'h0;
      check("bp_id",  bif.rsp_id,  1);
      check("bp_sum", bif.rsp_sum, 11);

      // pointer at 2, requests at 0 and 1: wrap picks 0 then 1
      bif.req_valid = 4'b0011;
      set_op(0, 4'd3, 4'd4);
      #1;
      check("wrap_ready0", bif.req_ready, 4'b0001);
      tick();
      check("wrap_id0",  bif.rsp_id,  0);
      check("wrap_sum0", bif.rsp_sum, 7);
      bif.req_valid = 4'b0010;
      #1;
      check("wrap_ready1", bif.req_ready, 4'b0010);
      tick();
      bif.req_valid = 4'h0;
      check("wrap_id1", bif.rsp_id, 1);

      // exhaustive operands through requester 0
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            bif.req_valid = 4'b0001;
            set_op(0, 4'(a), 4'(b));
            tick();
            check($sformatf("sum_%0d_%0d", a, b), bif.rsp_sum, a + b);
         end
      end
      bif.req_valid = 4'h0;
      check("sum_id", bif.rsp_id, 0);

      // reset while full with requester 3 waiting
      bif.req_valid = 4'b0001;
      set_op(0, 4'd2, 4'd3);
      tick();
      bif.rsp_ready = 1'b0;
      bif.req_valid = 4'b1000;
      set_op(3, 4'd9, 4'd4);
      tick();
      check("pre_rst_valid", bif.rsp_valid, 1);
      check("pre_rst_sum",   bif.rsp_sum,   5);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", bif.rsp_valid, 0);
      check("mid_rst_sum",   bif.rsp_sum,   0);
      check("mid_rst_ready", bif.req_ready, 0);
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bif.rsp_ready = 1'b1;
      #1;
      check("post_rst_ready", bif.req_ready, 4'b1000);
      tick();
      check("post_rst_id",  bif.rsp_id,  3);
      check("post_rst_sum", bif.rsp_sum, 13);
      bif.req_valid = 4'b1001;
      set_op(0, 4'd1, 4'd1);
      #1;
      check("post_rst_ptr", bif.req_ready, 4'b0001);
      tick();
      bif.req_valid = 4'h0;
      check("post_rst_id0",  bif.rsp_id,  0);
      check("post_rst_sum0", bif.rsp_sum, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
